// File: rtl/uart_core.sv
`timescale 1ns/1ps
// Parametrised full-duplex UART: independent TX and RX engines on one clock.
// Optional parity bit in both directions when the UART_PARITY_EN macro is defined.
module uart_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 txd,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] BIT_HALF  = CW'(CPB / 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t              tx_state, tx_state_n;
    logic [CW-1:0]          tx_cnt, tx_cnt_n;
    logic [3:0]             tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_n;
    logic                   txd_q, txd_n;
    logic                   tx_bit_end, tx_accept;
`ifdef UART_PARITY_EN
    logic                   tx_par, tx_par_n;
`endif

    // The last stop cycle is already "not busy" so a new request lands with no idle gap.
    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_done    = (tx_state == TX_STOP) && (tx_idx == STOP_LAST) && tx_bit_end;
    assign tx_busy    = (tx_state != TX_IDLE) && !tx_done;
    assign tx_accept  = tx_start && !tx_busy;
    assign txd        = txd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            txd_q    <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            txd_q    <= txd_n;
`ifdef UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_bit_end ? '0 : tx_cnt + 1'b1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        txd_n      = txd_q;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_n = TX_DATA;
                tx_idx_n   = '0;
                txd_n      = tx_shift[0];
            end
            TX_DATA: if (tx_bit_end) begin
                tx_shift_n = tx_shift >> 1;
                if (tx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    tx_state_n = TX_PARITY;
                    txd_n      = tx_par;
`else
                    tx_state_n = TX_STOP;
                    tx_idx_n   = '0;
                    txd_n      = 1'b1;
`endif
                end else begin
                    tx_idx_n = tx_idx + 1'b1;
                    txd_n    = tx_shift[1];
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_state_n = TX_STOP;
                tx_idx_n   = '0;
                txd_n      = 1'b1;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_idx == STOP_LAST) tx_state_n = TX_IDLE;
                else                     tx_idx_n   = tx_idx + 1'b1;
                txd_n = 1'b1;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_accept) begin
            tx_state_n = TX_START;
            tx_cnt_n   = '0;
            tx_shift_n = tx_data;
            txd_n      = 1'b0;
`ifdef UART_PARITY_EN
            tx_par_n   = (^tx_data) ^ ODD;
`endif
        end
    end

    rx_state_t              rx_state, rx_state_n;
    logic                   rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]          rx_cnt, rx_cnt_n;
    logic [3:0]             rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0]   rx_shift, rx_shift_n;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_n;
    logic                   rx_valid_q, rx_valid_n;
    logic                   rx_ferr_q, rx_ferr_n;
    logic                   rx_bit_end;
`ifdef UART_PARITY_EN
    logic                   rx_par_bit, rx_par_bit_n;
    logic                   rx_perr_q, rx_perr_n;
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign rx_bit_end   = (rx_cnt == BIT_LAST);
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bit <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_s1      <= rxd;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_idx     <= rx_idx_n;
            rx_shift   <= rx_shift_n;
            rx_data_q  <= rx_data_n;
            rx_valid_q <= rx_valid_n;
            rx_ferr_q  <= rx_ferr_n;
`ifdef UART_PARITY_EN
            rx_par_bit <= rx_par_bit_n;
            rx_perr_q  <= rx_perr_n;
`endif
        end
    end

    // The cycle that detects the falling edge counts as bit-time 0, so START samples mid-bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_bit_end ? '0 : rx_cnt + 1'b1;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data_q;
        rx_valid_n = 1'b0;
        rx_ferr_n  = rx_ferr_q;
`ifdef UART_PARITY_EN
        rx_par_bit_n = rx_par_bit;
        rx_perr_n    = rx_perr_q;
`endif
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = CW'(1);
                if (rx_prev && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: if (rx_cnt == BIT_HALF) begin
                rx_cnt_n = '0;
                if (rx_s2) begin
                    rx_state_n = RX_IDLE;
                end else begin
                    rx_state_n = RX_DATA;
                    rx_idx_n   = '0;
                end
            end
            RX_DATA: if (rx_bit_end) begin
                rx_shift_n = {rx_s2, rx_shift[DATA_BITS-1:1]};
                if (rx_idx == DATA_LAST) begin
`ifdef UART_PARITY_EN
                    rx_state_n = RX_PARITY;
`else
                    rx_state_n = RX_STOP;
`endif
                end else begin
                    rx_idx_n = rx_idx + 1'b1;
                end
            end
            RX_PARITY: if (rx_bit_end) begin
`ifdef UART_PARITY_EN
                rx_par_bit_n = rx_s2;
`endif
                rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_bit_end) begin
                rx_data_n  = rx_shift;
                rx_valid_n = 1'b1;
                rx_ferr_n  = !rx_s2;
`ifdef UART_PARITY_EN
                rx_perr_n  = rx_par_bit ^ (^rx_shift) ^ ODD;
`endif
                rx_state_n = rx_s2 ? RX_IDLE : RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: if (rx_s2) rx_state_n = RX_IDLE;
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule
